register_read_port: RTL

- Dual-operand read unit on the read side of the general register file.
- Takes the flattened register stream plus the file's write-side controls.
- Accepts a read request naming two source registers, returns both 32-bit operands one cycle later through a valid/ready handshake.
- Forwards a same-cycle write or clear, so the returned operands always match the file contents after the acceptance edge; feeds the ALU operand latches and the bus mux.

---
 rtl/reg_pkg.sv | 14 +
 rtl/reg_operand_select.sv | 43 ++++
 rtl/register_read_port.sv | 114 +++++++++++
 3 files changed

// File: rtl/reg_pkg.sv
// Shared constants and handshake state encoding for the register-file read port.
package reg_pkg;

    localparam int BITS      = 32;
    localparam int REGISTERS = 16;
    localparam int SELW      = $clog2(REGISTERS);

    // Response buffer occupancy: one held operand pair at most.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/reg_operand_select.sv
// One operand lane: picks a register out of the flattened file and applies
// the zero-register, same-cycle clear and same-cycle write forwarding rules
// so the result equals what the file will hold after the current edge.
module reg_operand_select #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16,
    parameter int SELW      = $clog2(REGISTERS),
    parameter int ZERO_R0   = 0
) (
    input  logic [SELW-1:0]           sel_i,
    input  logic [BITS*REGISTERS-1:0] stream_i,
    input  logic [BITS-1:0]           wr_data_i,
    input  logic [REGISTERS-1:0]      load_en_i,
    input  logic [REGISTERS-1:0]      clr_en_i,
    output logic [BITS-1:0]           data_o
);
    import reg_pkg::*;

    logic [BITS-1:0] slot_s;
    logic [BITS-1:0] data_s;

    // Resolve every slot with its priority chain, then OR in only the selected
    // one; an index with no matching slot leaves the result at zero.
    always_comb begin
        slot_s = '0;
        data_s = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if ((ZERO_R0 != 0) && (i == 0)) begin
                slot_s = '0;
            end else if (clr_en_i[i]) begin
                slot_s = '0;
            end else if (load_en_i[i]) begin
                slot_s = wr_data_i;
            end else begin
                slot_s = stream_i[i*BITS +: BITS];
            end
            data_s = data_s | ((sel_i == SELW'(i)) ? slot_s : '0);
        end
    end

    assign data_o = data_s;

endmodule

// File: rtl/register_read_port.sv
// Dual-operand read port of the general register file. Captures both operands
// at the acceptance edge into a one-entry response buffer and presents them
// through a valid/ready handshake one cycle later.
module register_read_port #(
    parameter int BITS      = reg_pkg::BITS,
    parameter int REGISTERS = reg_pkg::REGISTERS,
    parameter int SELW      = $clog2(REGISTERS),
    parameter int ZERO_R0   = 0
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [BITS*REGISTERS-1:0] registerStream,
    input  logic [BITS-1:0]           busMuxOut,
    input  logic [REGISTERS-1:0]      loadEnable,
    input  logic [REGISTERS-1:0]      regClr,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SELW-1:0]           req_selA,
    input  logic [SELW-1:0]           req_selB,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [BITS-1:0]           rsp_dataA,
    output logic [BITS-1:0]           rsp_dataB
);
    import reg_pkg::*;

    rd_state_t       state_q, state_d;
    logic [BITS-1:0] data_a_q, data_a_d;
    logic [BITS-1:0] data_b_q, data_b_d;
    logic [BITS-1:0] op_a_s, op_b_s;
    logic            accept_s;

    reg_operand_select #(
        .BITS      (BITS),
        .REGISTERS (REGISTERS),
        .SELW      (SELW),
        .ZERO_R0   (ZERO_R0)
    ) u_sel_a (
        .sel_i     (req_selA),
        .stream_i  (registerStream),
        .wr_data_i (busMuxOut),
        .load_en_i (loadEnable),
        .clr_en_i  (regClr),
        .data_o    (op_a_s)
    );

    reg_operand_select #(
        .BITS      (BITS),
        .REGISTERS (REGISTERS),
        .SELW      (SELW),
        .ZERO_R0   (ZERO_R0)
    ) u_sel_b (
        .sel_i     (req_selB),
        .stream_i  (registerStream),
        .wr_data_i (busMuxOut),
        .load_en_i (loadEnable),
        .clr_en_i  (regClr),
        .data_o    (op_b_s)
    );

    // Ready depends only on buffer state and the consumer, never on req_valid.
    assign req_ready = (state_q == ST_EMPTY) || rsp_ready;
    assign accept_s  = req_valid && req_ready;

    // Handshake next state and operand capture; held data only changes on accept.
    always_comb begin
        state_d  = state_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d  = ST_FULL;
                    data_a_d = op_a_s;
                    data_b_d = op_b_s;
                end else begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_d  = ST_FULL;
                    data_a_d = op_a_s;
                    data_b_d = op_b_s;
                end else if (rsp_ready) begin
                    state_d  = ST_EMPTY;
                end else begin
                    state_d  = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and output registers; clr wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_EMPTY;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            state_q  <= state_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_dataA = data_a_q;
    assign rsp_dataB = data_b_q;

endmodule
